// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp -- parametrised multi-port integer register file
//
// Multi-read / multi-write register file with optional hard-wired zero entry
// and optional same-cycle write-to-read forwarding.
//
// Parameters
//   XLEN      data width of every entry
//   NUM_REGS  number of entries (power of 2, >= 2)
//   NUM_RD    number of read ports
//   NUM_WR    number of write ports
//   ZERO_REG  1: entry 0 reads 0 and ignores writes
//   BYPASS    1: same-cycle write data forwarded to matching read ports
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset (clears storage and wr_collide)
//   write       per-port write enable
//   wa          write addresses, port p at [p*AW +: AW]
//   wd          write data, port p at [p*XLEN +: XLEN]
//   ra          read addresses, port r at [r*AW +: AW]
//   rd          read data, port r at [r*XLEN +: XLEN] (combinational)
//   wr_collide  registered flag: >= 2 enabled write ports hit the same
//               (non-zero when ZERO_REG) address in the previous cycle
// ---------------------------------------------------------------------------
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_WR-1:0]      write,
  input  logic [NUM_WR*AW-1:0]   wa,
  input  logic [NUM_WR*XLEN-1:0] wd,
  input  logic [NUM_RD*AW-1:0]   ra,
  output logic [NUM_RD*XLEN-1:0] rd,
  output logic                   wr_collide
);

  logic [XLEN-1:0] mem [NUM_REGS];
  logic            collide_now;

  // Per-port write qualification: address 0 is dropped when hard-wired.
  logic [NUM_WR-1:0] wr_ok;

  always_comb begin
    wr_ok = '0;
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      wr_ok[p] = write[p] &&
                 !((ZERO_REG != 0) && (wa[p*AW +: AW] == '0));
    end
  end

  // Any pair of qualified ports targeting the same address.
  always_comb begin
    collide_now = 1'b0;
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      for (int unsigned q = p + 1; q < NUM_WR; q++) begin
        if (wr_ok[p] && wr_ok[q] && (wa[p*AW +: AW] == wa[q*AW +: AW]))
          collide_now = 1'b1;
      end
    end
  end

  // Ports are visited in ascending order, so the last non-blocking
  // assignment (highest-index port) wins on an address collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        mem[i] <= '0;
      wr_collide <= 1'b0;
    end else begin
      for (int unsigned p = 0; p < NUM_WR; p++) begin
        if (wr_ok[p])
          mem[wa[p*AW +: AW]] <= wd[p*XLEN +: XLEN];
      end
      wr_collide <= collide_now;
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] val;

    assign addr = ra[r*AW +: AW];

    // Forwarding is suppressed while in reset so the port shows stored data;
    // the zero override is applied last so it also masks forwarded data.
    always_comb begin
      val = mem[addr];
      if ((BYPASS != 0) && rst_n) begin
        for (int unsigned p = 0; p < NUM_WR; p++) begin
          if (write[p] && (wa[p*AW +: AW] == addr))
            val = wd[p*XLEN +: XLEN];
        end
      end
      if ((ZERO_REG != 0) && (addr == '0))
        val = '0;
    end

    assign rd[r*XLEN +: XLEN] = val;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp -- directed self-checking bench for regfile_mp
//
// u_a: 2 write ports, ZERO_REG=1, BYPASS=1 (dual-issue configuration)
// u_b: 1 write port,  ZERO_REG=0, BYPASS=0
// ---------------------------------------------------------------------------
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [1:0]  wr_a;
  logic [9:0]  wa_a;
  logic [63:0] wd_a;
  logic [9:0]  ra_a;
  logic [63:0] rd_a;
  logic        col_a;

  logic [0:0]  wr_b;
  logic [4:0]  wa_b;
  logic [31:0] wd_b;
  logic [9:0]  ra_b;
  logic [63:0] rd_b;
  logic        col_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_a [32];
  logic [31:0] exp_b [32];
  logic [31:0] v, vb;
  logic [4:0]  ri, ro;
  int          port;

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2),
    .ZERO_REG(1), .BYPASS(1)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .write(wr_a), .wa(wa_a), .wd(wd_a),
    .ra(ra_a), .rd(rd_a), .wr_collide(col_a)
  );

  regfile_mp #(
    .XLEN(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(1),
    .ZERO_REG(0), .BYPASS(0)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .write(wr_b), .wa(wa_b), .wd(wd_b),
    .ra(ra_b), .rd(rd_b), .wr_collide(col_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      ra_a = {i[4:0], i[4:0]};
      ra_b = {i[4:0], i[4:0]};
      #1;
      chk({tag, "_a0"}, rd_a[31:0],  32'h0);
      chk({tag, "_a1"}, rd_a[63:32], 32'h0);
      chk({tag, "_b0"}, rd_b[31:0],  32'h0);
      chk({tag, "_b1"}, rd_b[63:32], 32'h0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wr_a = '0; wa_a = '0; wd_a = '0; ra_a = '0;
    wr_b = '0; wa_b = '0; wd_b = '0; ra_b = '0;

    // 1. reset, then every entry reads 0 on every port
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      exp_a[i] = '0;
      exp_b[i] = '0;
    end
    read_all_zero("rst");
    chk("rst_col_a", {31'h0, col_a}, 32'h0);
    chk("rst_col_b", {31'h0, col_b}, 32'h0);

    // 2. write each register with random data, read back on a random port
    for (int rnd = 0; rnd < 1000; rnd++) begin
      for (int i = 0; i < 32; i++) begin
        v  = $urandom;
        vb = $urandom;
        wr_a = 2'b01; wa_a = {5'd0, i[4:0]}; wd_a = {32'h0, v};
        wr_b = 1'b1;  wa_b = i[4:0];         wd_b = vb;
        tick();
        wr_a = '0;
        wr_b = '0;
        if (i != 0) exp_a[i] = v;
        exp_b[i] = vb;
        ri   = i[4:0];
        ro   = 5'($urandom_range(0, 31));
        port = $urandom_range(0, 1);
        if (port == 0) begin
          ra_a = {ro, ri};
          ra_b = {ro, ri};
        end else begin
          ra_a = {ri, ro};
          ra_b = {ri, ro};
        end
        #1;
        chk("rw_a_sel", (port == 0) ? rd_a[31:0]  : rd_a[63:32], exp_a[ri]);
        chk("rw_a_oth", (port == 0) ? rd_a[63:32] : rd_a[31:0],  exp_a[ro]);
        chk("rw_b_sel", (port == 0) ? rd_b[31:0]  : rd_b[63:32], exp_b[ri]);
        chk("rw_b_oth", (port == 0) ? rd_b[63:32] : rd_b[31:0],  exp_b[ro]);
      end
    end

    // reg 0: hard-wired on u_a (also through bypass), ordinary on u_b
    wr_a = 2'b01; wa_a = '0; wd_a = {32'h0, 32'hDEADBEEF}; ra_a = '0;
    wr_b = 1'b1;  wa_b = '0; wd_b = 32'hDEADBEEF;          ra_b = '0;
    #1;
    chk("z0_byp_a", rd_a[31:0], 32'h0);
    tick();
    wr_a = '0; wr_b = '0;
    exp_b[0] = 32'hDEADBEEF;
    #1;
    chk("z0_a",    rd_a[31:0], 32'h0);
    chk("z0_b",    rd_b[31:0], 32'hDEADBEEF);
    chk("z0_col_a", {31'h0, col_a}, 32'h0);

    // 3. bypass: u_a forwards before the edge, u_b shows old value until it
    wr_a = 2'b01; wa_a = {5'd0, 5'd5}; wd_a = {32'h0, 32'h12345678}; ra_a = {5'd5, 5'd5};
    wr_b = 1'b1;  wa_b = 5'd5;         wd_b = 32'h12345678;          ra_b = {5'd0, 5'd5};
    #1;
    chk("byp_a0",     rd_a[31:0],  32'h12345678);
    chk("byp_a1",     rd_a[63:32], 32'h12345678);
    chk("nobyp_b_pre", rd_b[31:0], exp_b[5]);
    tick();
    wr_a = '0; wr_b = '0;
    exp_a[5] = 32'h12345678;
    exp_b[5] = 32'h12345678;
    #1;
    chk("byp_a_post",   rd_a[31:0], 32'h12345678);
    chk("nobyp_b_post", rd_b[31:0], 32'h12345678);

    // 4. two ports write reg 7: port 1 wins, collision flagged one cycle
    wr_a = 2'b11; wa_a = {5'd7, 5'd7}; wd_a = {32'h00005555, 32'hAAAA0000};
    ra_a = {5'd0, 5'd7};
    #1;
    chk("col_byp", rd_a[31:0], 32'h00005555);
    chk("col_pre", {31'h0, col_a}, 32'h0);
    tick();
    wr_a = '0;
    exp_a[7] = 32'h00005555;
    #1;
    chk("col_store", rd_a[31:0], 32'h00005555);
    chk("col_flag1", {31'h0, col_a}, 32'h1);
    tick();
    chk("col_flag2", {31'h0, col_a}, 32'h0);

    // different addresses on both ports: both land, no collision
    wr_a = 2'b11; wa_a = {5'd9, 5'd8}; wd_a = {32'h99990009, 32'h88880008};
    tick();
    wr_a = '0;
    exp_a[8] = 32'h88880008;
    exp_a[9] = 32'h99990009;
    ra_a = {5'd9, 5'd8};
    #1;
    chk("dual_p0",  rd_a[31:0],  32'h88880008);
    chk("dual_p1",  rd_a[63:32], 32'h99990009);
    chk("dual_col", {31'h0, col_a}, 32'h0);

    // 5. both ports write address 0: ignored, no collision
    wr_a = 2'b11; wa_a = '0; wd_a = {32'h11111111, 32'h22222222}; ra_a = '0;
    tick();
    wr_a = '0;
    #1;
    chk("z0col_rd",  rd_a[31:0], 32'h0);
    chk("z0col_flag", {31'h0, col_a}, 32'h0);
    tick();
    chk("z0col_flag2", {31'h0, col_a}, 32'h0);

    // 6. fill 1..31, then reset with a write (and collision) pending
    for (int i = 1; i < 32; i++) begin
      wr_a = 2'b01; wa_a = {5'd0, i[4:0]}; wd_a = {32'h0, 32'hC0DE0000 | i};
      wr_b = 1'b1;  wa_b = i[4:0];         wd_b = 32'hB0B00000 | i;
      tick();
      exp_a[i] = 32'hC0DE0000 | i;
      exp_b[i] = 32'hB0B00000 | i;
    end
    wr_a = '0; wr_b = '0;
    ra_a = {5'd31, 5'd1};
    #1;
    chk("fill_a1",  rd_a[31:0],  32'hC0DE0001);
    chk("fill_a31", rd_a[63:32], 32'hC0DE001F);

    rst_n = 1'b0;
    wr_a = 2'b11; wa_a = {5'd3, 5'd3}; wd_a = {32'hFFFFFFFF, 32'hEEEEEEEE};
    wr_b = 1'b1;  wa_b = 5'd3;         wd_b = 32'hFFFFFFFF;
    ra_a = {5'd0, 5'd3};
    ra_b = {5'd0, 5'd3};
    #1;
    chk("rstbyp_a", rd_a[31:0], exp_a[3]);
    chk("rstbyp_b", rd_b[31:0], exp_b[3]);
    tick();
    rst_n = 1'b1;
    wr_a = '0; wr_b = '0;
    chk("rst2_col_a", {31'h0, col_a}, 32'h0);
    read_all_zero("rst2");
    tick();
    chk("rst2_col_a2", {31'h0, col_a}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
